alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Producer end of the execute-stage ALU interface in the RV32I pipeline.
- Takes a fetched instruction plus register-file read data from IF/ID and decodes the ALU operation into the 3-bit alu_ctrl/sral encoding.
- Selects and formats both ALU operands, then holds everything in an ID/EX pipeline register under a valid/ready handshake with stall and flush.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.
- ILLEGAL_AS_NOP, 1, when 1 an illegal instruction is issued with out_valid=1 as ADD 0+0 and illegal_e=1; when 0 it is dropped (out_valid stays 0) and illegal_e pulses.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  IF/ID holds an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- instr  in  32  instruction word
- pc  in  32  instruction address
- rs1_data  in  32  register file read port 1
- rs2_data  in  32  register file read port 2
- flush  in  1  kill the held instruction and any accepted this cycle (branch mispredict/trap)
- out_ready  in  1  execute stage consumes this cycle
- out_valid  out  1  ID/EX register holds a valid op
- alu_ctrl_e  out  3  ALU operation code
- sral_e  out  1  ALU sub-select
- src_a_e  out  32  ALU operand a
- src_b_e  out  32  ALU operand b
- is_branch_e  out  1  op is a conditional branch
- br_invert_e  out  1  branch taken when the ALU result is nonzero; BNE, BLT, BGE, BLTU and BGEU use the polarity listed under Behaviour
- illegal_e  out  1  op was not a supported RV32I ALU-using instruction

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, alu_ctrl_e=0, sral_e=0, src_a_e=0, src_b_e=0, is_branch_e=0, br_invert_e=0, illegal_e=0.
  - Reset may be asserted mid-handshake; the held op is lost.
- in_ready = !out_valid || out_ready. This is combinational; there is no dependency on in_valid.
- Register update each rising edge, in priority order:
  - flush=1: out_valid<=0, whatever in_valid/in_ready are.
  - Otherwise, in_valid && in_ready: load the decoded fields; out_valid<=1.
  - Otherwise, out_ready && out_valid: out_valid<=0, data fields hold.
  - Otherwise: hold everything (stall).
- Latency: exactly 1 cycle from acceptance to out_valid.
- Throughput: 1 op/cycle while out_ready=1.
- ALU encoding (fixed):
  - 000 sral=0 ADD; 000 sral=1 SUB.
  - 001 SLL; 010 AND; 011 OR; 100 SLTU; 101 SLT; 110 XOR.
  - 111 sral=1 SRL; 111 sral=0 SRA.
- Decode by opcode[6:0], funct3, funct7[5]:
  - OP (0110011): R-type, a=rs1, b=rs2. funct7[5] selects SUB vs ADD and SRA vs SRL.
  - OP-IMM (0010011): a=rs1, b=sign-extended I-imm. ADDI always has sral=0. SRAI/SRLI use funct7[5].
  - Shift operands: every shift has b = {27'b0, amount[4:0]}. For register shifts, amount = rs2_data[4:0]; for immediate shifts, amount = instr[24:20]. The ALU shifts by the full operand, so the upper bits must be zero.
  - LOAD (0000011): ADD, a=rs1, b=I-imm.
  - STORE (0100011): ADD, a=rs1, b=S-imm.
  - LUI: ADD, a=0, b=U-imm.
  - AUIPC: ADD, a=pc, b=U-imm.
  - JAL/JALR: ADD, a=pc, b=4 (link value).
  - BRANCH (1100011): is_branch_e=1, a=rs1, b=rs2, with this mapping:
    - BEQ: SUB, invert=0 (taken on zero).
    - BNE: SUB, invert=1.
    - BLT: SLT, invert=1.
    - BGE: SLT, invert=0.
    - BLTU: SLTU, invert=1.
    - BGEU: SLTU, invert=0.
- Illegal: any other opcode, funct3 010/011 on BRANCH, funct7 not in {0000000, 0100000} on OP, or funct7[5]=1 with funct3 other than 000/101 on OP. Handling follows ILLEGAL_AS_NOP.
- Simultaneous flush and out_ready: flush wins; the op is not reported twice.

Test Plan:
- Reset, then instr=0x40B50533 (sub a0,a0,a1), rs1=10, rs2=3, out_ready=1 -> next cycle out_valid=1, alu_ctrl_e=000, sral_e=1, src_a_e=10, src_b_e=3.
- srai x5,x6,4 (0x40435293), rs1=0x80000000 -> alu_ctrl_e=111, sral_e=0, src_b_e=0x00000004; sll with rs2=0xFFFFFF21 -> src_b_e=0x00000001.
- bgeu (0x00B57463) -> alu_ctrl_e=100, is_branch_e=1, br_invert_e=0; lui x1,0x12345 -> src_a_e=0, src_b_e=0x12345000, sral_e=0.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, all outputs stable; then out_ready=1 -> back-to-back ops with no loss or duplication.
- Assert flush in the same cycle as accept and out_ready=0 -> out_valid=0 next cycle; asserting rst_n=0 mid-stall clears outputs immediately, without waiting for a clock edge.
- instr=0xFFFFFFFF with ILLEGAL_AS_NOP=1 -> out_valid=1, illegal_e=1, alu_ctrl_e=000, src_a_e=src_b_e=0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes RV32I instructions into the 3-bit ALU encoding, formats both
// operands and holds the result in a valid/ready pipeline register with stall and flush.
module alu_issue_stage #(
  parameter int unsigned WIDTH          = 32,
  parameter bit          ILLEGAL_AS_NOP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [2:0]       alu_ctrl_e,
  output logic             sral_e,
  output logic [WIDTH-1:0] src_a_e,
  output logic [WIDTH-1:0] src_b_e,
  output logic             is_branch_e,
  output logic             br_invert_e,
  output logic             illegal_e
);

  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSll  = 3'b001;
  localparam logic [2:0] AluAnd  = 3'b010;
  localparam logic [2:0] AluOr   = 3'b011;
  localparam logic [2:0] AluSltu = 3'b100;
  localparam logic [2:0] AluSlt  = 3'b101;
  localparam logic [2:0] AluXor  = 3'b110;
  localparam logic [2:0] AluSr   = 3'b111;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  // funct3 of OP/OP-IMM to ALU code; the sral bit is resolved separately.
  function automatic logic [2:0] f3_to_ctrl(input logic [2:0] f3);
    logic [2:0] c;
    case (f3)
      3'b000:  c = AluAdd;
      3'b001:  c = AluSll;
      3'b010:  c = AluSlt;
      3'b011:  c = AluSltu;
      3'b100:  c = AluXor;
      3'b101:  c = AluSr;
      3'b110:  c = AluOr;
      default: c = AluAnd;
    endcase
    return c;
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_u;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};

  logic [2:0]  dec_ctrl;
  logic        dec_sral, dec_br, dec_inv, dec_ill;
  logic [31:0] dec_a, dec_b;

  always_comb begin
    dec_ctrl = AluAdd;
    dec_sral = 1'b0;
    dec_a    = rs1_data;
    dec_b    = rs2_data;
    dec_br   = 1'b0;
    dec_inv  = 1'b0;
    dec_ill  = 1'b0;
    case (opcode)
      OpcOp: begin
        dec_ctrl = f3_to_ctrl(funct3);
        if (funct3 == 3'b000) dec_sral = funct7[5];
        if (funct3 == 3'b101) dec_sral = ~funct7[5];
        if (funct3 == 3'b001 || funct3 == 3'b101) dec_b = {27'b0, rs2_data[4:0]};
        if ((funct7 & 7'b1011111) != 7'b0) dec_ill = 1'b1;
        if (funct7[5] && funct3 != 3'b000 && funct3 != 3'b101) dec_ill = 1'b1;
      end
      OpcOpImm: begin
        dec_ctrl = f3_to_ctrl(funct3);
        dec_b    = imm_i;
        if (funct3 == 3'b001 || funct3 == 3'b101) dec_b = {27'b0, instr[24:20]};
        if (funct3 == 3'b101) dec_sral = ~funct7[5];
      end
      OpcLoad:  dec_b = imm_i;
      OpcStore: dec_b = imm_s;
      OpcLui: begin
        dec_a = 32'b0;
        dec_b = imm_u;
      end
      OpcAuipc: begin
        dec_a = pc;
        dec_b = imm_u;
      end
      OpcJal, OpcJalr: begin
        dec_a = pc;
        dec_b = 32'd4;
      end
      OpcBranch: begin
        dec_br = 1'b1;
        case (funct3)
          3'b000: dec_sral = 1'b1;
          3'b001: begin
            dec_sral = 1'b1;
            dec_inv  = 1'b1;
          end
          3'b100: begin
            dec_ctrl = AluSlt;
            dec_inv  = 1'b1;
          end
          3'b101: dec_ctrl = AluSlt;
          3'b110: begin
            dec_ctrl = AluSltu;
            dec_inv  = 1'b1;
          end
          3'b111: dec_ctrl = AluSltu;
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    // Illegal ops become ADD 0+0 with no branch side effects.
    if (dec_ill) begin
      dec_ctrl = AluAdd;
      dec_sral = 1'b0;
      dec_a    = 32'b0;
      dec_b    = 32'b0;
      dec_br   = 1'b0;
      dec_inv  = 1'b0;
    end
  end

  logic             valid_q, valid_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic             sral_q, sral_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             br_q, br_d, inv_q, inv_d, ill_q, ill_d;
  logic             accept;

  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    sral_d  = sral_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    inv_d   = inv_q;
    // A dropped illegal op only reports itself for one cycle.
    ill_d   = ILLEGAL_AS_NOP ? ill_q : 1'b0;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = ILLEGAL_AS_NOP | ~dec_ill;
      ctrl_d  = dec_ctrl;
      sral_d  = dec_sral;
      a_d     = dec_a;
      b_d     = dec_b;
      br_d    = dec_br;
      inv_d   = dec_inv;
      ill_d   = dec_ill;
    end else if (out_ready && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= 3'b0;
      sral_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      inv_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      sral_q  <= sral_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      inv_q   <= inv_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid   = valid_q;
  assign alu_ctrl_e  = ctrl_q;
  assign sral_e      = sral_q;
  assign src_a_e     = a_q;
  assign src_b_e     = b_q;
  assign is_branch_e = br_q;
  assign br_invert_e = inv_q;
  assign illegal_e   = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed instruction table, handshake corner sequences and
// randomized instructions built from mnemonics with their expected ALU fields.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, in_ready, flush, out_ready, out_valid;
  logic [31:0] instr, pc, rs1_data, rs2_data, src_a_e, src_b_e;
  logic [2:0]  alu_ctrl_e;
  logic        sral_e, is_branch_e, br_invert_e, illegal_e;

  alu_issue_stage #(.WIDTH(32), .ILLEGAL_AS_NOP(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .pc         (pc),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .flush      (flush),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .alu_ctrl_e (alu_ctrl_e),
    .sral_e     (sral_e),
    .src_a_e    (src_a_e),
    .src_b_e    (src_b_e),
    .is_branch_e(is_branch_e),
    .br_invert_e(br_invert_e),
    .illegal_e  (illegal_e)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic [2:0]  ctrl;
    logic        sral;
    logic [31:0] a, b;
    logic        br, inv, ill;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic        m_valid;
  vec_t        m_exp;
  vec_t        idle;
  vec_t        tab[$];
  logic [2:0]  rtab [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [2:0] c, input logic s,
                              input logic [31:0] a, input logic [31:0] b, input logic br,
                              input logic inv, input logic ill);
    vec_t v;
    v.instr = ins; v.pc = p; v.rs1 = r1; v.rs2 = r2; v.ctrl = c; v.sral = s;
    v.a = a; v.b = b; v.br = br; v.inv = inv; v.ill = ill;
    return v;
  endfunction

  function automatic logic legal_op(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63};
  endfunction

  // Builds a random instruction from a mnemonic class and states its expected ALU fields.
  function automatic vec_t rand_vec();
    vec_t        v;
    int          kind;
    logic [4:0]  rd, r1, r2, sh;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    logic        alt;
    logic [11:0] imm;
    logic [19:0] imm20;
    v.rs1 = $urandom; v.rs2 = $urandom; v.pc = $urandom;
    v.sral = 1'b0; v.br = 1'b0; v.inv = 1'b0; v.ill = 1'b0; v.ctrl = 3'b000;
    rd = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom); sh = 5'($urandom);
    f3 = 3'($urandom); alt = 1'($urandom); imm = 12'($urandom); imm20 = 20'($urandom);
    kind = $urandom_range(0, 7);
    v.a = v.rs1;
    case (kind)
      0: begin  // register-register ALU op
        if (f3 != 3'd0 && f3 != 3'd5) alt = 1'b0;
        v.instr = {alt ? 7'h20 : 7'h00, r2, r1, f3, rd, 7'h33};
        v.ctrl  = rtab[f3];
        v.sral  = (f3 == 3'd0) ? alt : (f3 == 3'd5) ? !alt : 1'b0;
        v.b     = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, v.rs2[4:0]} : v.rs2;
      end
      1: begin  // register-immediate ALU op
        if (f3 == 3'd1) imm = {7'h00, sh};
        if (f3 == 3'd5) imm = {alt ? 7'h20 : 7'h00, sh};
        v.instr = {imm, r1, f3, rd, 7'h13};
        v.ctrl  = rtab[f3];
        v.sral  = (f3 == 3'd5) ? !alt : 1'b0;
        v.b     = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, sh} : {{20{imm[11]}}, imm};
      end
      2: begin
        v.instr = {imm, r1, f3, rd, 7'h03};
        v.b     = {{20{imm[11]}}, imm};
      end
      3: begin
        v.instr = {imm[11:5], r2, r1, f3, imm[4:0], 7'h23};
        v.b     = {{20{imm[11]}}, imm};
      end
      4: begin  // LUI when alt, AUIPC otherwise
        v.instr = {imm20, rd, alt ? 7'h37 : 7'h17};
        v.a     = alt ? 32'd0 : v.pc;
        v.b     = {imm20, 12'b0};
      end
      5: begin  // JAL when alt, JALR otherwise
        v.instr = alt ? {imm20, rd, 7'h6F} : {imm, r1, 3'b000, rd, 7'h67};
        v.a     = v.pc;
        v.b     = 32'd4;
      end
      6: begin
        case ($urandom_range(0, 5))
          0: begin f3 = 3'd0; v.ctrl = 3'b000; v.sral = 1'b1; end  // BEQ
          1: begin f3 = 3'd1; v.ctrl = 3'b000; v.sral = 1'b1; v.inv = 1'b1; end
          2: begin f3 = 3'd4; v.ctrl = 3'b101; v.inv = 1'b1; end
          3: begin f3 = 3'd5; v.ctrl = 3'b101; end
          4: begin f3 = 3'd6; v.ctrl = 3'b100; v.inv = 1'b1; end
          default: begin f3 = 3'd7; v.ctrl = 3'b100; end
        endcase
        v.instr = {imm[11:5], r2, r1, f3, imm[4:0], 7'h63};
        v.br    = 1'b1;
        v.b     = v.rs2;
      end
      default: begin  // illegal encodings
        v.instr = $urandom;
        case ($urandom_range(0, 2))
          0: begin
            op = 7'($urandom);
            while (legal_op(op)) op = 7'($urandom);
            v.instr[6:0] = op;
          end
          1: begin
            v.instr[6:0]   = 7'h63;
            v.instr[14:12] = {2'b01, alt};
          end
          default: begin
            v.instr[6:0] = 7'h33;
            if (alt) begin
              f7 = 7'($urandom);
              while ((f7 & 7'b1011111) == 7'd0) f7 = 7'($urandom);
            end else begin
              f7 = 7'h20;
              while (f3 == 3'd0 || f3 == 3'd5) f3 = 3'($urandom);
              v.instr[14:12] = f3;
            end
            v.instr[31:25] = f7;
          end
        endcase
        v.ill = 1'b1; v.a = 32'd0; v.b = 32'd0;
      end
    endcase
    return v;
  endfunction

  task automatic check_outputs(input logic ordy);
    chk("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("alu_ctrl_e", 32'(alu_ctrl_e), 32'(m_exp.ctrl));
      chk("sral_e", 32'(sral_e), 32'(m_exp.sral));
      chk("src_a_e", src_a_e, m_exp.a);
      chk("src_b_e", src_b_e, m_exp.b);
      chk("is_branch_e", 32'(is_branch_e), 32'(m_exp.br));
      chk("br_invert_e", 32'(br_invert_e), 32'(m_exp.inv));
      chk("illegal_e", 32'(illegal_e), 32'(m_exp.ill));
    end
  endtask

  // One clock: drive, check the held op, then advance the handshake model across the edge.
  task automatic cycle(input logic iv, input vec_t v, input logic ordy, input logic fl);
    logic rdy;
    in_valid = iv; instr = v.instr; pc = v.pc; rs1_data = v.rs1; rs2_data = v.rs2;
    out_ready = ordy; flush = fl;
    #1;
    check_outputs(ordy);
    rdy = !m_valid || ordy;
    @(posedge clk);
    if (fl) m_valid = 1'b0;
    else if (iv && rdy) begin
      m_valid = 1'b1;
      m_exp   = v;
    end else if (ordy && m_valid) m_valid = 1'b0;
    #1;
  endtask

  task automatic check_reset_values();
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst alu_ctrl_e", 32'(alu_ctrl_e), 32'd0);
    chk("rst sral_e", 32'(sral_e), 32'd0);
    chk("rst src_a_e", src_a_e, 32'd0);
    chk("rst src_b_e", src_b_e, 32'd0);
    chk("rst is_branch_e", 32'(is_branch_e), 32'd0);
    chk("rst br_invert_e", 32'(br_invert_e), 32'd0);
    chk("rst illegal_e", 32'(illegal_e), 32'd0);
  endtask

  initial begin
    rtab[0] = 3'b000; rtab[1] = 3'b001; rtab[2] = 3'b101; rtab[3] = 3'b100;
    rtab[4] = 3'b110; rtab[5] = 3'b111; rtab[6] = 3'b011; rtab[7] = 3'b010;
    idle = mk(32'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    m_valid = 1'b0;
    m_exp   = idle;

    //      instr          pc            rs1           rs2           ctrl  sral a             b            br inv ill
    tab.push_back(mk(32'h40B50533, 32'h0,   32'd10,       32'd3,        3'b000, 1, 32'd10,       32'd3,       0, 0, 0));
    tab.push_back(mk(32'h40435293, 32'h4,   32'h80000000, 32'h5,        3'b111, 0, 32'h80000000, 32'd4,       0, 0, 0));
    tab.push_back(mk(32'h003110B3, 32'h8,   32'h77,       32'hFFFFFF21, 3'b001, 0, 32'h77,       32'd1,       0, 0, 0));
    tab.push_back(mk(32'h00B57463, 32'hC,   32'h5,        32'h6,        3'b100, 0, 32'h5,        32'h6,       1, 0, 0));
    tab.push_back(mk(32'h123450B7, 32'h10,  32'hDEAD,     32'hBEEF,     3'b000, 0, 32'd0,        32'h12345000, 0, 0, 0));
    tab.push_back(mk(32'hFFFFFFFF, 32'h14,  32'h1234,     32'h5678,     3'b000, 0, 32'd0,        32'd0,       0, 0, 1));
    tab.push_back(mk(32'h00001097, 32'h100, 32'h9,        32'h9,        3'b000, 0, 32'h100,      32'h1000,    0, 0, 0));
    tab.push_back(mk(32'h0000006F, 32'h200, 32'h9,        32'h9,        3'b000, 0, 32'h200,      32'd4,       0, 0, 0));
    tab.push_back(mk(32'hFFC12083, 32'h0,   32'h1000,     32'h9,        3'b000, 0, 32'h1000,     32'hFFFFFFFC, 0, 0, 0));
    tab.push_back(mk(32'h00312423, 32'h0,   32'h2000,     32'h9,        3'b000, 0, 32'h2000,     32'd8,       0, 0, 0));
    tab.push_back(mk(32'h00002063, 32'h0,   32'h1,        32'h2,        3'b000, 0, 32'd0,        32'd0,       0, 0, 1));
    tab.push_back(mk(32'h00B54063, 32'h0,   32'h1,        32'h2,        3'b101, 0, 32'h1,        32'h2,       1, 1, 0));
    tab.push_back(mk(32'h40B51533, 32'h0,   32'h1,        32'h2,        3'b000, 0, 32'd0,        32'd0,       0, 0, 1));
    tab.push_back(mk(32'h02B50533, 32'h0,   32'h1,        32'h2,        3'b000, 0, 32'd0,        32'd0,       0, 0, 1));
    tab.push_back(mk(32'hFFF54513, 32'h0,   32'h0F0F,     32'h2,        3'b110, 0, 32'h0F0F,     32'hFFFFFFFF, 0, 0, 0));
    tab.push_back(mk(32'h00B55533, 32'h0,   32'h80000000, 32'hFFFFFFE7, 3'b111, 1, 32'h80000000, 32'd7,       0, 0, 0));

    in_valid = 0; instr = 0; pc = 0; rs1_data = 0; rs2_data = 0; flush = 0; out_ready = 0;
    #1 rst_n = 1'b0;
    #1;
    check_reset_values();
    chk("rst in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tab[i]) cycle(1'b1, tab[i], 1'b1, 1'b0);
    cycle(1'b0, idle, 1'b1, 1'b0);

    // Stall three cycles with a pending op, then drain back-to-back.
    cycle(1'b1, tab[0], 1'b0, 1'b0);
    repeat (3) cycle(1'b1, tab[1], 1'b0, 1'b0);
    cycle(1'b1, tab[1], 1'b1, 1'b0);
    cycle(1'b1, tab[2], 1'b1, 1'b0);
    cycle(1'b0, idle, 1'b1, 1'b0);
    cycle(1'b0, idle, 1'b1, 1'b0);

    // Flush on the accepting cycle, then flush racing out_ready on a held op.
    cycle(1'b1, tab[3], 1'b0, 1'b1);
    cycle(1'b1, tab[4], 1'b0, 1'b0);
    cycle(1'b0, idle, 1'b1, 1'b1);
    cycle(1'b0, idle, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a stall.
    cycle(1'b1, tab[6], 1'b0, 1'b0);
    cycle(1'b1, tab[7], 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values();
    m_valid = 1'b0;
    m_exp   = idle;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(1'b0, idle, 1'b1, 1'b0);

    repeat (800) begin
      cycle($urandom_range(0, 3) != 0, rand_vec(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0);
    end
    repeat (2) cycle(1'b0, idle, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
